// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared Hamming(7,4) types and helper functions for the
//                transmit (encode) and receive (syndrome/correct/extract)
//                sides of the TMR-Hamming datapath.
//                Codeword index i holds Hamming position i+1:
//                cw = {d3,d2,d1,p4,d0,p2,p1}
//  Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

   typedef logic [6:0] code_t;
   typedef logic [3:0] data_t;
   typedef logic [2:0] syndrome_t;

   // Corrected-error counter state, derived from the counter value itself
   typedef enum logic [1:0] {
      CNT_IDLE  = 2'd0,
      CNT_COUNT = 2'd1,
      CNT_SAT   = 2'd2
   } cnt_state_t;

   function automatic code_t hamming_encode(input data_t d);
      logic p1;
      logic p2;
      logic p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   // Returns {s4,s2,s1}; a nonzero value is the Hamming position in error
   function automatic syndrome_t hamming_syndrome(input code_t c);
      return {c[3] ^ c[4] ^ c[5] ^ c[6],
              c[1] ^ c[2] ^ c[5] ^ c[6],
              c[0] ^ c[2] ^ c[4] ^ c[6]};
   endfunction

   // Flips the bit at position s (index s-1); s == 0 leaves the word untouched
   function automatic code_t hamming_correct(input code_t c, input syndrome_t s);
      code_t r;
      r = c;
      if (s != 3'd0) begin
         r = c ^ (code_t'(1) << (s - 3'd1));
      end
      return r;
   endfunction

   function automatic data_t hamming_extract(input code_t c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/hamming74_err_stats.sv
`default_nettype none
// ============================================================================
//  Module      : hamming74_err_stats
//  Description : Saturating corrected-word counter plus last error position.
//                Driven by corrected-word output handshakes; clr_count wins
//                over a simultaneous increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming74_err_stats
   import hamming_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_count,
   input  logic             evt_valid,
   input  syndrome_t        evt_pos,
   output logic [CNT_W-1:0] err_count,
   output syndrome_t        last_err_pos
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   syndrome_t        pos_q;
   syndrome_t        pos_d;
   cnt_state_t       w_cnt_state;

   // Classify the counter value: empty, counting, or pinned at maximum
   always_comb begin
      w_cnt_state = CNT_COUNT;
      if (count_q == '0) begin
         w_cnt_state = CNT_IDLE;
      end else if (count_q == c_cnt_max) begin
         w_cnt_state = CNT_SAT;
      end
   end

   // Next counter / position: clear first, then count non-saturated events
   always_comb begin
      count_d = count_q;
      pos_d   = pos_q;
      if (clr_count) begin
         count_d = '0;
         pos_d   = 3'd0;
      end else if (evt_valid) begin
         pos_d = evt_pos;
         if (w_cnt_state != CNT_SAT) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         pos_q   <= 3'd0;
      end else begin
         count_q <= count_d;
         pos_q   <= pos_d;
      end
   end

   assign err_count    = count_q;
   assign last_err_pos = pos_q;

endmodule
`default_nettype wire

// File: rtl/hamming74_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hamming74_rx_decoder
//  Description : Two-stage valid/ready Hamming(7,4) decoder. S1 registers the
//                codeword and its syndrome, S2 corrects a single-bit error
//                and registers the data word. Double-bit errors miscorrect
//                (inherent to the code; no detection attempted).
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming74_rx_decoder
   import hamming_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic             out_corrected,
   output logic [2:0]       out_syndrome,
   input  logic             clr_count,
   output logic [CNT_W-1:0] err_count,
   output logic [2:0]       last_err_pos
);

   logic      s1_valid_q, s1_valid_d;
   code_t     s1_code_q,  s1_code_d;
   syndrome_t s1_syn_q,   s1_syn_d;
   logic      out_valid_q, out_valid_d;
   data_t     out_data_q,  out_data_d;
   logic      out_corr_q,  out_corr_d;
   syndrome_t out_syn_q,   out_syn_d;

   logic      w_advance;
   logic      w_in_ready;
   logic      w_err_evt;

   // S2 may take a new word whenever it is empty or being drained
   assign w_advance  = !out_valid_q || out_ready;
   assign w_in_ready = !s1_valid_q || w_advance;
   assign w_err_evt  = out_valid_q && out_ready && out_corr_q;

   // S1 next state: capture codeword and syndrome when input side is open
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_code_d  = s1_code_q;
      s1_syn_d   = s1_syn_q;
      if (w_in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_code_d = in_code;
            s1_syn_d  = hamming_syndrome(in_code);
         end
      end
   end

   // S2 next state: correct and extract; bubbles pass through as invalid
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_corr_d  = out_corr_q;
      out_syn_d   = out_syn_q;
      if (w_advance) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = hamming_extract(hamming_correct(s1_code_q, s1_syn_q));
            out_corr_d = (s1_syn_q != 3'd0);
            out_syn_d  = s1_syn_q;
         end
      end
   end

   // Pipeline registers; reset drops any in-flight words
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_code_q   <= '0;
         s1_syn_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_corr_q  <= 1'b0;
         out_syn_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_code_q   <= s1_code_d;
         s1_syn_q    <= s1_syn_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_corr_q  <= out_corr_d;
         out_syn_q   <= out_syn_d;
      end
   end

   hamming74_err_stats #(
      .CNT_W (CNT_W)
   ) u_err_stats (
      .clk          (clk),
      .rst          (rst),
      .clr_count    (clr_count),
      .evt_valid    (w_err_evt),
      .evt_pos      (out_syn_q),
      .err_count    (err_count),
      .last_err_pos (last_err_pos)
   );

   assign in_ready      = w_in_ready;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_corrected = out_corr_q;
   assign out_syndrome  = out_syn_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming74_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming74_rx_decoder
//  Description : Directed table-driven bench for hamming74_rx_decoder. A
//                second instance with CNT_W=2 shares the stimulus to observe
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming74_rx_decoder;

   typedef struct {
      logic [6:0] code;
      logic [3:0] data;
      logic       corr;
      logic [2:0] syn;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [6:0] in_code;
   logic       out_ready;
   logic       clr_count;

   logic       in_ready,  b_in_ready;
   logic       out_valid, b_out_valid;
   logic [3:0] out_data,  b_out_data;
   logic       out_corr,  b_out_corr;
   logic [2:0] out_syn,   b_out_syn;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic [2:0] pos_a,     pos_b;

   int   n_checks = 0;
   int   n_errs   = 0;
   int   n_out    = 0;
   vec_t cur_exp;
   vec_t expq[$];
   vec_t tbl[12];
   vec_t bp[5];
   bit   bp_done;

   always #5 clk = ~clk;

   hamming74_rx_decoder #(.CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_corrected(out_corr), .out_syndrome(out_syn),
      .clr_count(clr_count), .err_count(cnt_a), .last_err_pos(pos_a)
   );

   hamming74_rx_decoder #(.CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_code(in_code), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_corrected(b_out_corr), .out_syndrome(b_out_syn),
      .clr_count(clr_count), .err_count(cnt_b), .last_err_pos(pos_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input vec_t v);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_code  = v.code;
      cur_exp  = v;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_left", expq.size(), 0);
   endtask

   // Scoreboard: record accepted words, compare delivered words in order
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
      end else begin
         if (in_valid && in_ready) expq.push_back(cur_exp);
         if (out_valid && out_ready) begin
            n_out++;
            if (expq.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else begin
               vec_t e;
               e = expq.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_corrected", out_corr, e.corr);
               chk("out_syndrome", out_syn, e.syn);
            end
         end
      end
   end

   initial begin
      // code, data, corrected, syndrome (hand-computed)
      tbl[0]  = '{7'b1010010, 4'b1010, 1'b0, 3'd0}; // clean encode(1010)
      tbl[1]  = '{7'b1000010, 4'b1010, 1'b1, 3'd5};
      tbl[2]  = '{7'b0000100, 4'b0000, 1'b1, 3'd3};
      tbl[3]  = '{7'b1100111, 4'b1101, 1'b1, 3'd1}; // encode(1101)=1100110
      tbl[4]  = '{7'b1100100, 4'b1101, 1'b1, 3'd2};
      tbl[5]  = '{7'b1100010, 4'b1101, 1'b1, 3'd3};
      tbl[6]  = '{7'b1101110, 4'b1101, 1'b1, 3'd4};
      tbl[7]  = '{7'b1110110, 4'b1101, 1'b1, 3'd5};
      tbl[8]  = '{7'b1000110, 4'b1101, 1'b1, 3'd6};
      tbl[9]  = '{7'b0100110, 4'b1101, 1'b1, 3'd7};
      tbl[10] = '{7'b1111111, 4'b1111, 1'b0, 3'd0};
      tbl[11] = '{7'b0000111, 4'b0001, 1'b0, 3'd0}; // encode(0001)

      bp[0] = '{7'b0000000, 4'b0000, 1'b0, 3'd0};
      bp[1] = '{7'b0000111, 4'b0001, 1'b0, 3'd0};
      bp[2] = '{7'b1010010, 4'b1010, 1'b0, 3'd0};
      bp[3] = '{7'b1100110, 4'b1101, 1'b0, 3'd0};
      bp[4] = '{7'b1111111, 4'b1111, 1'b0, 3'd0};

      rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; clr_count = 1'b0;
      cur_exp = tbl[0];
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_corrected", out_corr, 0);
      chk("rst_out_syndrome", out_syn, 0);
      chk("rst_err_count", cnt_a, 0);
      chk("rst_last_err_pos", pos_a, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table vectors back to back
      for (int i = 0; i < 12; i++) send(tbl[i]);
      drain();
      @(posedge clk); #1;
      chk("cnt_after_table", cnt_a, 9);
      chk("cnt_sat_w2", cnt_b, 3);
      chk("last_pos_table", pos_a, 7);
      chk("words_table", n_out, 12);

      // Latency plus clear colliding with a corrected handshake
      in_valid = 1'b1; in_code = 7'b1000010; cur_exp = tbl[1];
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_edge1_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_edge2_valid", out_valid, 1);
      clr_count = 1'b1;
      @(posedge clk); #1;
      clr_count = 1'b0;
      chk("clr_cnt_a", cnt_a, 0);
      chk("clr_cnt_b", cnt_b, 0);
      chk("clr_pos", pos_a, 0);

      // Counting resumes from zero after clear
      send(tbl[6]);
      drain();
      @(posedge clk); #1;
      chk("cnt_after_clr", cnt_a, 1);
      chk("pos_after_clr", pos_a, 4);

      // Backpressure: stall sink while streaming five words
      n_out = 0;
      out_ready = 1'b0;
      bp_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(bp[i]);
            bp_done = 1'b1;
         end
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_data", out_data, bp[0].data);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int n = 0; n < 100 && !bp_done; n++) begin
         @(posedge clk); #1;
      end
      chk("bp_sender_done", bp_done, 1);
      drain();
      chk("bp_words", n_out, 5);

      // Reset with two corrupted words in flight
      out_ready = 1'b0;
      send(tbl[1]);
      send(tbl[2]);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_cnt", cnt_a, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      n_out = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_no_stale", n_out, 0);
      chk("midrst_cnt_after", cnt_a, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
